// File: rtl/img_pkg.sv
// Shared image constants, angle codes and column_feeder state encoding.
// The optional zero-padding mode of column_feeder is enabled with `define ZERO_PAD_EN.
package img_pkg;

    localparam int unsigned IMG_WIDTH  = 960;
    localparam int unsigned IMG_HEIGHT = 720;
    localparam int unsigned BIT_LENGTH = 5;

    // Gradient direction codes carried alongside each pixel.
    typedef enum logic [1:0] {
        AngHoriz   = 2'd0,
        AngDiag45  = 2'd1,
        AngVert    = 2'd2,
        AngDiag135 = 2'd3
    } angle_e;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StStream,
        StFlush,
        StDone
    } state_e;

    // Counter/address width that stays legal for a depth of one.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line buffer: read-before-write, registered read data.
// Storage is not reset; only the read register is.
module line_ram
    import img_pkg::*;
#(
    parameter int unsigned DEPTH = 960,
    parameter int unsigned WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         we,
    input  logic [addr_width(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register captures the word as it was before this cycle's write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/column_feeder.sv
// Raster-to-column front end for NMS: buffers two lines and emits one vertical
// 3-pixel column per accepted pixel, plus the centre-row angle.
// Optional feature: `define ZERO_PAD_EN zero-pads the top and bottom rows and
// adds a FLUSH phase that emits the last row's columns without input.
//
// The two line RAMs are used ping-pong: row r is written into RAM (r % 2), which
// at that column still holds row r-2 (returned by the read-before-write port),
// while the other RAM holds row r-1. This gives the r-2/r-1 line pair of a
// copy-down scheme without a same-cycle RAM-to-RAM transfer.
module column_feeder #(
    parameter int unsigned IMG_WIDTH  = img_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = img_pkg::IMG_HEIGHT,
    parameter int unsigned BIT_LENGTH = img_pkg::BIT_LENGTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [BIT_LENGTH-1:0] pixel_in,
    input  logic [1:0]            angle_in,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic [1:0]            angle_out,
    output logic                  enable,
    output logic                  done,
    output logic                  err
);
    import img_pkg::*;

    localparam int unsigned CW = addr_width(IMG_WIDTH);
    localparam int unsigned RW = addr_width(IMG_HEIGHT + 1);
    localparam int unsigned DW = BIT_LENGTH + 2;
`ifdef ZERO_PAD_EN
    localparam int unsigned FIRST_ROW = 1;
`else
    localparam int unsigned FIRST_ROW = 2;
`endif
    // During flush the virtual row is IMG_HEIGHT; its "r-2" line sits in this RAM.
    localparam logic FLUSH_SEL = (IMG_HEIGHT % 2) == 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic                  accept, flush_rd;
    logic                  enable_d, done_d, err_d;
    logic                  last_col, last_row, fill_end_row, pad_top;
    logic                  top_sel_q, top_zero_q, bot_zero_q;
    logic [BIT_LENGTH-1:0] pix2_q;
    logic [DW-1:0]         rd0, rd1, mid_word;

    assign last_col     = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row     = (row_q == RW'(IMG_HEIGHT - 1));
    assign fill_end_row = (row_q == RW'(FIRST_ROW - 1));
`ifdef ZERO_PAD_EN
    assign pad_top = (row_q == RW'(1));
`else
    assign pad_top = 1'b0;
`endif

    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DW)) u_lb0 (
        .clk   (clk),
        .reset (reset),
        .en    (accept || flush_rd),
        .we    (accept && !row_q[0]),
        .addr  (col_q),
        .wdata ({pixel_in, angle_in}),
        .rdata (rd0)
    );

    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(DW)) u_lb1 (
        .clk   (clk),
        .reset (reset),
        .en    (accept || flush_rd),
        .we    (accept && row_q[0]),
        .addr  (col_q),
        .wdata ({pixel_in, angle_in}),
        .rdata (rd1)
    );

    // Next-state and status decode.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        flush_rd = 1'b0;
        enable_d = 1'b0;
        done_d   = done;
        err_d    = err;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (last_col && fill_end_row) begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    enable_d = 1'b1;
                    if (last_col && last_row) begin
`ifdef ZERO_PAD_EN
                        state_d = StFlush;
`else
                        state_d = StDone;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StFlush: begin
                flush_rd = 1'b1;
                enable_d = 1'b1;
                if (last_col) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters, status flags and column side-band registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            enable     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            top_sel_q  <= 1'b0;
            top_zero_q <= 1'b0;
            bot_zero_q <= 1'b0;
            pix2_q     <= '0;
        end else begin
            state_q <= state_d;
            enable  <= enable_d;
            done    <= done_d;
            err     <= err_d;
            if (accept || flush_rd) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                top_sel_q  <= flush_rd ? FLUSH_SEL : row_q[0];
                top_zero_q <= accept && pad_top;
                bot_zero_q <= flush_rd;
            end
            if (accept) begin
                pix2_q <= pixel_in;
            end
        end
    end

    // Route the two RAM read registers to the top/centre column slots.
    always_comb begin
        mid_word   = top_sel_q ? rd0 : rd1;
        pixel_out0 = top_zero_q ? '0 : (top_sel_q ? rd1[DW-1:2] : rd0[DW-1:2]);
        pixel_out1 = mid_word[DW-1:2];
        pixel_out2 = bot_zero_q ? '0 : pix2_q;
        angle_out  = mid_word[1:0];
    end

endmodule

// File: tb/tb_column_feeder.sv
// Self-checking bench for column_feeder on a 4x4 image; honours `define ZERO_PAD_EN.
module tb_column_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int BL = 5;
    localparam int CB = 3 * BL + 2;
`ifdef ZERO_PAD_EN
    localparam int FIRST_ROW = 1;
    localparam int NCOLS     = H * W;
    localparam int TAIL      = W;
`else
    localparam int FIRST_ROW = 2;
    localparam int NCOLS     = (H - 2) * W;
    localparam int TAIL      = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [BL-1:0] pixel_in = '0;
    logic [1:0]    angle_in = '0;
    logic [BL-1:0] pixel_out0, pixel_out1, pixel_out2;
    logic [1:0]    angle_out;
    logic          enable, done, err;

    int errors = 0;
    int checks = 0;

    logic [BL-1:0] pix [H][W];
    logic [1:0]    ang [H][W];
    logic [CB-1:0] got [$];
    logic [CB-1:0] exp_q [$];
    int cyc = 0, drv_idx = 0, rises = 0, first_en = -1, last_en = -1;
    logic prev_en = 1'b0;

    column_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BIT_LENGTH(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .pixel_in   (pixel_in),
        .angle_in   (angle_in),
        .pixel_out0 (pixel_out0),
        .pixel_out1 (pixel_out1),
        .pixel_out2 (pixel_out2),
        .angle_out  (angle_out),
        .enable     (enable),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // One cycle: sample outputs at the falling edge, then drive the next input.
    task automatic tick(input logic v, input logic [BL-1:0] p, input logic [1:0] a);
        @(negedge clk);
        if (enable) begin
            got.push_back({pixel_out0, pixel_out1, pixel_out2, angle_out});
            if (!prev_en) rises++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        prev_en  = enable;
        drv_idx  = cyc;
        cyc++;
        in_valid = v;
        pixel_in = p;
        angle_in = a;
    endtask

    task automatic clear_capture();
        got.delete();
        rises = 0; first_en = -1; last_en = -1; prev_en = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_capture();
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                pix[r][c] = BL'(r * W + c);
                ang[r][c] = 2'(c);
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                pix[r][c] = BL'($urandom);
                ang[r][c] = 2'($urandom);
            end
    endtask

    function automatic logic [BL-1:0] px(input int r, input int c);
        return (r < 0 || r >= H) ? '0 : pix[r][c];
    endfunction

    // Reference: every raster position before stop_flat that lies in an output row
    // yields the column (r-2, r-1, r); out-of-image rows read as zero.
    task automatic build_expected(input int stop_flat);
        exp_q.delete();
        for (int f = 0; f < stop_flat; f++) begin
            int r, c;
            r = f / W;
            c = f % W;
            if (r >= FIRST_ROW) exp_q.push_back({px(r - 2, c), px(r - 1, c), px(r, c), ang[r - 1][c]});
        end
`ifdef ZERO_PAD_EN
        if (stop_flat == H * W)
            for (int c = 0; c < W; c++)
                exp_q.push_back({px(H - 2, c), px(H - 1, c), BL'(0), ang[H - 1][c]});
`endif
    endtask

    task automatic send_frame(input bit gaps, input int drop_flat,
                              output int first_idx, output int last_idx, output int drop_idx);
        first_idx = -1; last_idx = -1; drop_idx = -1;
        for (int f = 0; f < H * W; f++) begin
            int r, c;
            r = f / W;
            c = f % W;
            if (gaps && r < FIRST_ROW) repeat ($urandom_range(0, 3)) tick(1'b0, BL'($urandom), 2'($urandom));
            if (f == drop_flat) begin
                tick(1'b0, BL'($urandom), 2'($urandom));
                drop_idx = drv_idx;
            end
            tick(1'b1, pix[r][c], ang[r][c]);
            if (r == FIRST_ROW && c == 0) first_idx = drv_idx;
            last_idx = drv_idx;
        end
        repeat (W + 4) tick(1'b0, BL'($urandom), 2'($urandom));
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; pixel_in = 5'h1f; angle_in = 2'd3;
        #1;
        checks++; if ({pixel_out0, pixel_out1, pixel_out2, angle_out} !== '0)
            begin errors++; $display("FAIL reset_data got=%h exp=0", {pixel_out0, pixel_out1, pixel_out2, angle_out}); end
        checks++; if ({enable, done, err} !== 3'b000)
            begin errors++; $display("FAIL reset_flags got=%b exp=000", {enable, done, err}); end
        repeat (2) @(negedge clk);
        checks++; if ({pixel_out0, pixel_out1, pixel_out2, angle_out} !== '0)
            begin errors++; $display("FAIL reset_held_data got=%h exp=0", {pixel_out0, pixel_out1, pixel_out2, angle_out}); end
        in_valid = 1'b0;
        reset = 1'b1;
        clear_capture();
        repeat (4) tick(1'b0, 5'h1f, 2'd3);
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL idle_enable got=%0d exp=0", got.size()); end
        checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL idle_flags got=%b exp=00", {done, err}); end
    endtask

    task automatic test_ramp();
        int fi, li, di;
        clear_capture();
        fill_ramp();
        send_frame(1'b0, -1, fi, li, di);
        build_expected(H * W);
        checks++; if (got.size() !== NCOLS) begin errors++; $display("FAIL ramp_count got=%0d exp=%0d", got.size(), NCOLS); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ramp_col%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
`ifdef ZERO_PAD_EN
        checks++; if (got.size() > 0 && got[0] !== {5'd0, 5'd0, 5'd4, 2'd0})
            begin errors++; $display("FAIL ramp_first got=%h exp=%h", got[0], {5'd0, 5'd0, 5'd4, 2'd0}); end
`else
        checks++; if (got.size() > 0 && got[0] !== {5'd0, 5'd4, 5'd8, 2'd0})
            begin errors++; $display("FAIL ramp_first got=%h exp=%h", got[0], {5'd0, 5'd4, 5'd8, 2'd0}); end
`endif
        checks++; if (rises !== 1) begin errors++; $display("FAIL ramp_gapless got=%0d exp=1", rises); end
        checks++; if (first_en !== fi + 1) begin errors++; $display("FAIL ramp_first_en got=%0d exp=%0d", first_en, fi + 1); end
        checks++; if (last_en !== li + 1 + TAIL) begin errors++; $display("FAIL ramp_last_en got=%0d exp=%0d", last_en, li + 1 + TAIL); end
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL ramp_status got=%b exp=10", {done, err}); end
    endtask

    task automatic test_back_to_back();
        int fi, li, di;
        clear_capture();
        fill_random();
        send_frame(1'b0, -1, fi, li, di);
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL b2b_count got=%0d exp=0", got.size()); end
        checks++; if ({done, err, enable} !== 3'b100) begin errors++; $display("FAIL b2b_status got=%b exp=100", {done, err, enable}); end
    endtask

    task automatic test_gaps();
        int fi, li, di;
        do_reset();
        fill_ramp();
        send_frame(1'b1, -1, fi, li, di);
        build_expected(H * W);
        checks++; if (got.size() !== NCOLS) begin errors++; $display("FAIL gaps_count got=%0d exp=%0d", got.size(), NCOLS); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_col%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++; if (rises !== 1) begin errors++; $display("FAIL gaps_gapless got=%0d exp=1", rises); end
        checks++; if (first_en !== fi + 1) begin errors++; $display("FAIL gaps_first_en got=%0d exp=%0d", first_en, fi + 1); end
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL gaps_status got=%b exp=10", {done, err}); end
    endtask

    task automatic test_drop();
        int fi, li, di;
        do_reset();
        fill_ramp();
        send_frame(1'b0, 3 * W + 1, fi, li, di);
        build_expected(3 * W + 1);
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL drop_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL drop_col%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++; if (last_en !== di) begin errors++; $display("FAIL drop_enable_fall got=%0d exp=%0d", last_en, di); end
        checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL drop_status got=%b exp=11", {done, err}); end
    endtask

    task automatic test_reset_mid();
        int fi, li, di;
        do_reset();
        fill_random();
        for (int f = 0; f <= 2 * W + 2; f++) tick(1'b1, pix[f / W][f % W], ang[f / W][f % W]);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if ({pixel_out0, pixel_out1, pixel_out2, angle_out} !== '0)
            begin errors++; $display("FAIL abort_data got=%h exp=0", {pixel_out0, pixel_out1, pixel_out2, angle_out}); end
        checks++; if ({enable, done, err} !== 3'b000) begin errors++; $display("FAIL abort_flags got=%b exp=000", {enable, done, err}); end
        @(negedge clk);
        reset = 1'b1;
        clear_capture();
        fill_ramp();
        send_frame(1'b0, -1, fi, li, di);
        build_expected(H * W);
        checks++; if (got.size() !== NCOLS) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", got.size(), NCOLS); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL abort_col%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        checks++; if (first_en !== fi + 1) begin errors++; $display("FAIL abort_first_en got=%0d exp=%0d", first_en, fi + 1); end
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL abort_status got=%b exp=10", {done, err}); end
    endtask

    task automatic test_random();
        int fi, li, di;
        for (int n = 0; n < 3; n++) begin
            do_reset();
            fill_random();
            send_frame(1'b1, -1, fi, li, di);
            build_expected(H * W);
            checks++; if (got.size() !== NCOLS) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, got.size(), NCOLS); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_col%0d got=%h exp=%h", n, i, got[i], exp_q[i]); end
            end
            checks++; if (rises !== 1) begin errors++; $display("FAIL rand%0d_gapless got=%0d exp=1", n, rises); end
            checks++; if (last_en !== li + 1 + TAIL) begin errors++; $display("FAIL rand%0d_last_en got=%0d exp=%0d", n, last_en, li + 1 + TAIL); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_gaps();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
